// File: rtl/writeback_stage.sv
// Writeback stage: selects the result source, writes the register file
// and tracks retirement; loads that miss their data wait in WAIT_MEM.
module writeback_stage (
    input  logic        Clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        iValid,
    input  logic [31:0] iIC,
    input  logic [31:0] iPC,
    input  logic [4:0]  iRDS,
    input  logic        iRegWrite,
    input  logic [1:0]  iWBSel,
    input  logic [31:0] iALU,
    input  logic [31:0] iMemData,
    input  logic        iMemReady,
    output logic        rf_we,
    output logic [4:0]  WAddr,
    output logic [31:0] WData,
    output logic        oStallReq,
    output logic [31:0] oRetired,
    output logic [31:0] oLastIC
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_e;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;
    localparam logic [1:0] SEL_RSV  = 2'b11;

    state_e      state_q, state_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        stall_req_q, stall_req_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] last_ic_q, last_ic_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_we_q, pend_we_d;
    logic [31:0] pend_ic_q, pend_ic_d;

    logic        accept;
    logic        retire;
    logic [31:0] retire_ic;

    assign accept = (state_q == IDLE) && !stall && !flush && iValid;

    always_comb begin
        state_d     = state_q;
        rf_we_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        stall_req_d = stall_req_q;
        pend_rd_d   = pend_rd_q;
        pend_we_d   = pend_we_q;
        pend_ic_d   = pend_ic_q;
        retire      = 1'b0;
        retire_ic   = iIC;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (iWBSel)
                        SEL_ALU: begin
                            retire  = 1'b1;
                            rf_we_d = iRegWrite;
                            waddr_d = iRDS;
                            wdata_d = iALU;
                        end
                        SEL_LINK: begin
                            retire  = 1'b1;
                            rf_we_d = iRegWrite;
                            waddr_d = iRDS;
                            wdata_d = iPC + 32'd4;
                        end
                        SEL_MEM: begin
                            if (iMemReady) begin
                                retire  = 1'b1;
                                rf_we_d = iRegWrite;
                                waddr_d = iRDS;
                                wdata_d = iMemData;
                            end else begin
                                pend_rd_d   = iRDS;
                                pend_we_d   = iRegWrite;
                                pend_ic_d   = iIC;
                                stall_req_d = 1'b1;
                                state_d     = WAIT_MEM;
                            end
                        end
                        SEL_RSV: begin
                            retire = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_MEM: begin
                // The pending load is older than anything upstream, so
                // stall/flush and new instructions are ignored here.
                if (iMemReady) begin
                    retire      = 1'b1;
                    retire_ic   = pend_ic_q;
                    rf_we_d     = pend_we_q;
                    waddr_d     = pend_rd_q;
                    wdata_d     = iMemData;
                    stall_req_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    stall_req_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        retired_d = retire ? retired_q + 32'd1 : retired_q;
        last_ic_d = retire ? retire_ic : last_ic_q;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rf_we_q     <= 1'b0;
            waddr_q     <= 5'd0;
            wdata_q     <= 32'd0;
            stall_req_q <= 1'b0;
            retired_q   <= 32'd0;
            last_ic_q   <= 32'd0;
            pend_rd_q   <= 5'd0;
            pend_we_q   <= 1'b0;
            pend_ic_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            stall_req_q <= stall_req_d;
            retired_q   <= retired_d;
            last_ic_q   <= last_ic_d;
            pend_rd_q   <= pend_rd_d;
            pend_we_q   <= pend_we_d;
            pend_ic_q   <= pend_ic_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign WAddr     = waddr_q;
    assign WData     = wdata_q;
    assign oStallReq = stall_req_q;
    assign oRetired  = retired_q;
    assign oLastIC   = last_ic_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: scoreboard of expected register writes
// plus per-scenario checks of stall, retirement count and last tag.
module tb_writeback_stage;

    logic        Clk = 1'b0;
    logic        reset, stall, flush, iValid;
    logic [31:0] iIC, iPC;
    logic [4:0]  iRDS;
    logic        iRegWrite;
    logic [1:0]  iWBSel;
    logic [31:0] iALU, iMemData;
    logic        iMemReady;
    logic        rf_we;
    logic [4:0]  WAddr;
    logic [31:0] WData;
    logic        oStallReq;
    logic [31:0] oRetired, oLastIC;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    writeback_stage dut (
        .Clk       (Clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .iValid    (iValid),
        .iIC       (iIC),
        .iPC       (iPC),
        .iRDS      (iRDS),
        .iRegWrite (iRegWrite),
        .iWBSel    (iWBSel),
        .iALU      (iALU),
        .iMemData  (iMemData),
        .iMemReady (iMemReady),
        .rf_we     (rf_we),
        .WAddr     (WAddr),
        .WData     (WData),
        .oStallReq (oStallReq),
        .oRetired  (oRetired),
        .oLastIC   (oLastIC)
    );

    // Every register write must match the oldest expected write
    always @(negedge Clk) begin
        if (rf_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                         WAddr, WData);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (WAddr !== e.a || WData !== e.d) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             WAddr, WData, e.a, e.d);
                end
            end
        end
    end

    task automatic idle_inputs();
        reset     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        iValid    = 1'b0;
        iIC       = 32'd0;
        iPC       = 32'd0;
        iRDS      = 5'd0;
        iRegWrite = 1'b0;
        iWBSel    = 2'b00;
        iALU      = 32'd0;
        iMemData  = 32'd0;
        iMemReady = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if ({rf_we, WAddr, WData, oStallReq, oRetired, oLastIC} !== '0) begin
            bad++;
            $display("FAIL reset: got we=%b a=%0d d=%h st=%b ret=%0d ic=%0d, expected all 0",
                     rf_we, WAddr, WData, oStallReq, oRetired, oLastIC);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        iValid = 1'b1; iWBSel = 2'b00; iRegWrite = 1'b1;
        iRDS = 5'd1; iALU = 32'h1; iIC = 32'd7;
        exp_q.push_back('{5'd1, 32'h1});
        @(negedge Clk);
        iValid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || oRetired !== 32'd1 || oLastIC !== 32'd7) begin
            bad++;
            $display("FAIL alu: got we=%b ret=%0d ic=%0d, expected we=1 ret=1 ic=7",
                     rf_we, oRetired, oLastIC);
        end
        @(negedge Clk);
        total++;
        if (rf_we !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse: got we=%b, expected 0", rf_we);
        end
    endtask

    task automatic test_link();
        iValid = 1'b1; iWBSel = 2'b10; iRegWrite = 1'b1;
        iRDS = 5'd0; iPC = 32'd8; iIC = 32'd9;
        exp_q.push_back('{5'd0, 32'h0000000C});
        @(negedge Clk);
        iValid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || oRetired !== 32'd2 || oLastIC !== 32'd9) begin
            bad++;
            $display("FAIL link: got we=%b ret=%0d ic=%0d, expected we=1 ret=2 ic=9",
                     rf_we, oRetired, oLastIC);
        end
    endtask

    task automatic test_load_wait();
        iValid = 1'b1; iWBSel = 2'b01; iRegWrite = 1'b1;
        iRDS = 5'd2; iIC = 32'd20; iMemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            iValid = 1'b0;
            total++;
            if (oStallReq !== 1'b1 || rf_we !== 1'b0) begin
                bad++;
                $display("FAIL load_wait[%0d]: got st=%b we=%b, expected st=1 we=0",
                         i, oStallReq, rf_we);
            end
        end
        iMemReady = 1'b1; iMemData = 32'hFFFF8000;
        exp_q.push_back('{5'd2, 32'hFFFF8000});
        @(negedge Clk);
        iMemReady = 1'b0;
        total++;
        if (oStallReq !== 1'b0 || rf_we !== 1'b1 ||
            oRetired !== 32'd3 || oLastIC !== 32'd20) begin
            bad++;
            $display("FAIL load_done: got st=%b we=%b ret=%0d ic=%0d, expected 0 1 3 20",
                     oStallReq, rf_we, oRetired, oLastIC);
        end
    endtask

    task automatic test_stall_flush();
        iValid = 1'b1; iWBSel = 2'b00; iRegWrite = 1'b1;
        iRDS = 5'd5; iALU = 32'hDEAD; iIC = 32'd30; stall = 1'b1;
        @(negedge Clk);
        stall = 1'b0; flush = 1'b1;
        total++;
        if (rf_we !== 1'b0 || oRetired !== 32'd3) begin
            bad++;
            $display("FAIL stall: got we=%b ret=%0d, expected we=0 ret=3", rf_we, oRetired);
        end
        @(negedge Clk);
        flush = 1'b0; iValid = 1'b0;
        total++;
        if (rf_we !== 1'b0 || oRetired !== 32'd3) begin
            bad++;
            $display("FAIL flush_idle: got we=%b ret=%0d, expected we=0 ret=3",
                     rf_we, oRetired);
        end
    endtask

    task automatic test_flush_wait();
        iValid = 1'b1; iWBSel = 2'b01; iRegWrite = 1'b1;
        iRDS = 5'd9; iIC = 32'd40; iMemReady = 1'b0;
        @(negedge Clk);
        flush = 1'b1; iIC = 32'd41; iRDS = 5'd10;
        iWBSel = 2'b00; iALU = 32'h5;
        @(negedge Clk);
        iMemReady = 1'b1; iMemData = 32'h1234_5678;
        exp_q.push_back('{5'd9, 32'h1234_5678});
        @(negedge Clk);
        flush = 1'b0; iValid = 1'b0; iMemReady = 1'b0;
        total++;
        if (rf_we !== 1'b1 || oLastIC !== 32'd40 ||
            oRetired !== 32'd4 || oStallReq !== 1'b0) begin
            bad++;
            $display("FAIL flush_wait: got we=%b ic=%0d ret=%0d st=%b, expected 1 40 4 0",
                     rf_we, oLastIC, oRetired, oStallReq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        logic [31:0] ed;
        base = oRetired;
        for (int i = 0; i < 12; i++) begin
            iValid    = 1'b1;
            iWBSel    = 2'($urandom_range(0, 3));
            iRegWrite = (i % 5) != 3;
            iRDS      = 5'($urandom);
            iALU      = $urandom;
            iPC       = $urandom;
            iMemData  = $urandom;
            iMemReady = 1'b1;
            iIC       = 32'd100 + 32'(i);
            ed = (iWBSel == 2'b00) ? iALU :
                 (iWBSel == 2'b10) ? iPC + 32'd4 : iMemData;
            if (iRegWrite && iWBSel != 2'b11)
                exp_q.push_back('{iRDS, ed});
            @(negedge Clk);
            total++;
            if (oRetired !== base + 32'(i) + 32'd1 || oLastIC !== 32'd100 + 32'(i)) begin
                bad++;
                $display("FAIL b2b[%0d]: got ret=%0d ic=%0d, expected ret=%0d ic=%0d",
                         i, oRetired, oLastIC, base + 32'(i) + 32'd1, 32'd100 + 32'(i));
            end
        end
        iValid = 1'b0; iMemReady = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset_wait();
        iValid = 1'b1; iWBSel = 2'b01; iRegWrite = 1'b1;
        iRDS = 5'd7; iIC = 32'd55; iMemReady = 1'b0;
        @(negedge Clk);
        iValid = 1'b0; reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        total++;
        if ({rf_we, WAddr, WData, oStallReq, oRetired, oLastIC} !== '0) begin
            bad++;
            $display("FAIL reset_wait: got we=%b a=%0d d=%h st=%b ret=%0d ic=%0d, expected all 0",
                     rf_we, WAddr, WData, oStallReq, oRetired, oLastIC);
        end
        iMemReady = 1'b1; iMemData = 32'hAAAA5555;
        repeat (2) @(negedge Clk);
        iMemReady = 1'b0;
        total++;
        if (rf_we !== 1'b0 || oRetired !== 32'd0 || oStallReq !== 1'b0) begin
            bad++;
            $display("FAIL dropped_load: got we=%b ret=%0d st=%b, expected 0 0 0",
                     rf_we, oRetired, oStallReq);
        end
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        iValid = 1'b1; iWBSel = 2'b00; iRegWrite = 1'b1;
        iRDS = 5'd3; iALU = 32'h77; iIC = 32'd66;
        exp_q.push_back('{5'd3, 32'h77});
        @(negedge Clk);
        iValid = 1'b0;
        total++;
        if (oRetired !== 32'd0 || oLastIC !== 32'd66) begin
            bad++;
            $display("FAIL wrap: got ret=%h ic=%0d, expected ret=0 ic=66", oRetired, oLastIC);
        end
        @(negedge Clk);
    endtask

    initial begin
        idle_inputs();
        @(negedge Clk);
        test_reset();
        test_alu();
        test_link();
        test_load_wait();
        test_stall_flush();
        test_flush_wait();
        test_back_to_back();
        test_reset_wait();
        test_wrap();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have a single clock `Clk` and a synchronous, active-high reset `reset`.
REQ-002 Port: Clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: stall  in  1  hold the stage and do not accept new input.
REQ-005 Port: flush  in  1  discard the incoming instruction (treat it as invalid).
REQ-006 Port: iValid  in  1  incoming instruction valid.
REQ-007 Port: iIC  in  32  instruction counter tag of the incoming instruction.
REQ-008 Port: iPC  in  32  PC of the incoming instruction.
REQ-009 Port: iRDS  in  5  destination register address.
REQ-010 Port: iRegWrite  in  1  instruction writes the register file.
REQ-011 Port: iWBSel  in  2  writeback source: 00 = ALU, 01 = memory, 10 = link (iPC+4), 11 = reserved.
REQ-012 Port: iALU  in  32  ALU result.
REQ-013 Port: iMemData  in  32  load data.
REQ-014 Port: iMemReady  in  1  iMemData is valid this cycle.
REQ-015 Port: rf_we  out  1  register-file write enable, to the decode stage.
REQ-016 Port: WAddr  out  5  register-file write address.
REQ-017 Port: WData  out  32  register-file write data.
REQ-018 Port: oStallReq  out  1  stall request to the upstream pipeline.
REQ-019 Port: oRetired  out  32  count of retired instructions.
REQ-020 Port: oLastIC  out  32  iIC of the most recently retired instruction.

Function
REQ-021 SHALL implement a two-state FSM with states IDLE and WAIT_MEM; all outputs SHALL be registered.
REQ-022 Accept condition: state is IDLE, stall=0, flush=0, and iValid=1; the accept is evaluated on each rising edge.
REQ-023 In IDLE with stall=1 or flush=1, the block SHALL accept nothing; rf_we=0 on the next cycle and no other state changes.
REQ-024 On accept with iWBSel=00, iWBSel=10, or iWBSel=01 with iMemReady=1, the next cycle SHALL show:
- rf_we = iRegWrite;
- WAddr = iRDS;
- WData = iALU, iPC+4 (mod 2^32), or iMemData respectively.
REQ-025 On accept with iWBSel=11, the block SHALL retire the instruction with rf_we=0.
REQ-026 On accept with iWBSel=01 and iMemReady=0, the block SHALL:
- latch iRDS, iRegWrite and iIC;
- enter WAIT_MEM;
- assert oStallReq=1 on the next cycle;
- drive rf_we=0.
REQ-027 In WAIT_MEM with iMemReady=1, the next cycle SHALL show:
- rf_we = latched iRegWrite;
- WAddr = latched iRDS;
- WData = iMemData;
- oStallReq = 0;
- state = IDLE.
REQ-028 In WAIT_MEM with iMemReady=0, the block SHALL hold state, keep oStallReq=1 and drive rf_we=0.
REQ-029 In WAIT_MEM, stall, flush and all instruction inputs SHALL be ignored.
REQ-030 The pending load SHALL complete regardless of flush, because it is older than the flushed instruction.
REQ-031 rf_we SHALL be a single-cycle pulse for each retirement; it SHALL be 0 in every other cycle.
REQ-032 Retirement happens in the cycle rf_we would be driven, either at REQ-024/025 or at REQ-027 completion.
REQ-033 On each retirement:
- oRetired increments by 1 and wraps from 0xFFFFFFFF to 0;
- oLastIC updates to the retiring instruction's iIC.
REQ-034 Writes to register 0 SHALL be issued like any other address; the block applies no r0 special-casing.
REQ-035 Back-to-back accepts in IDLE SHALL sustain one retirement per cycle with latency 1.

Reset
REQ-036 reset=1 at a rising edge SHALL force, on the next cycle:
- state = IDLE;
- rf_we = 0, WAddr = 0, WData = 0;
- oStallReq = 0;
- oRetired = 0, oLastIC = 0.
REQ-037 reset SHALL take priority over all inputs, including in WAIT_MEM, where the pending load SHALL be dropped without any write.

Verification
REQ-038 ALU path: iValid=1, iWBSel=00, iRegWrite=1, iRDS=1, iALU=0x00000001, iIC=7 -> next cycle rf_we=1, WAddr=1, WData=1, oRetired=1, oLastIC=7; rf_we=0 the cycle after.
REQ-039 Link path: iWBSel=10, iRDS=0, iPC=8 -> next cycle rf_we=1, WAddr=0, WData=0x0000000C.
REQ-040 Load wait:
- stimulus: iWBSel=01, iRDS=2, iMemReady=0 for 3 cycles, then iMemReady=1 with iMemData=0xFFFF8000;
- response: oStallReq=1 for 3 cycles with rf_we=0, then a single rf_we=1 with WAddr=2, WData=0xFFFF8000;
- oStallReq returns to 0 in the same cycle as the rf_we pulse.
REQ-041 Stall/flush:
- valid instruction with stall=1 -> rf_we stays 0 and oRetired unchanged;
- flush=1 asserted during WAIT_MEM -> the load still completes.
REQ-042 Reset in WAIT_MEM: reset=1 while waiting -> next cycle all outputs 0 and state IDLE; a subsequent iMemReady=1 produces no write.
REQ-043 Counter wrap: preload oRetired to 0xFFFFFFFF by forcing, then one retirement -> oRetired=0.
